mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: BUSY cycles without m_ready before abort; only used when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 i_req  input  1  instruction-fetch request (read-only).
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_rdata  output  32  fetch read data; valid while i_ack=1.
REQ-007 i_ack  output  1  fetch completion; one-cycle pulse.
REQ-008 d_req  input  1  data request.
REQ-009 d_we  input  1  data write (1) / read (0).
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  data write data.
REQ-012 d_be  input  4  data byte enables.
REQ-013 d_rdata  output  32  data read data; valid while d_ack=1.
REQ-014 d_ack  output  1  data completion; one-cycle pulse.
REQ-015 m_req  output  1  shared-memory request; held until accepted.
REQ-016 m_we, m_addr, m_wdata, m_be  output  1/32/32/4  shared-memory command fields.
REQ-017 m_rdata  input  32  shared-memory read data, valid with m_ready.
REQ-018 m_ready  input  1  shared-memory completion.
REQ-019 busy  output  1  high in BUSY and RESP states.
REQ-020 timeout_err  output  1  one-cycle abort pulse, coincident with the aborted ack.

Function
REQ-021 FSM states: IDLE, BUSY, RESP; IDLE->BUSY on any req; BUSY->RESP on m_ready (or timeout); RESP->IDLE unconditionally.
REQ-022 Arbitration occurs only in IDLE: a single requester is granted; with both requesting, grant goes to the port not recorded in last_grant (round-robin); last_grant updates on every grant.
REQ-023 On grant, command fields are registered (i port: m_we=0, m_be=4'hF, m_wdata=0); m_req=1 from the next cycle; fields stay stable throughout BUSY.
REQ-024 In BUSY, m_ready=1 latches m_rdata and deasserts m_req next cycle; m_ready outside BUSY is ignored.
REQ-025 In RESP the granted port's ack=1 for exactly one cycle, with latched data on its rdata; the other port's ack=0.
REQ-026 Latency: req at cycle 0 in IDLE, m_ready at cycle k (k>=1) -> ack at cycle k+1; minimum request-to-ack is 2 cycles.
REQ-027 Requester contract: hold req and fields until ack; req still high in the cycle after ack is a new request.
REQ-028 i_rdata/d_rdata hold their last value between acks; on writes, d_rdata is undefined-but-stable (it holds m_rdata as latched).
REQ-029 Request changes during BUSY/RESP are not sampled; the losing requester waits, at most one transaction (fairness bound).

Reset
REQ-030 rst_n=0 forces: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_be=0, i_ack=d_ack=0, i_rdata=d_rdata=0, busy=0, timeout_err=0, counter=0, last_grant=I (first contention grants D).
REQ-031 Reset mid-transaction aborts without ack; the first grant occurs in the first IDLE cycle after release.

Configuration
REQ-032 Macro ARB_TIMEOUT_EN defined: BUSY cycles are counted; at count==TIMEOUT_CYCLES without m_ready -> m_req drops, RESP with ack=1, rdata=0, timeout_err=1; counter clears on BUSY entry.
REQ-033 ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err tied 0; TIMEOUT_CYCLES ignored.
REQ-034 m_ready and timeout in the same cycle: m_ready wins, normal completion, no error.

Verification
REQ-035 Single fetch: i_req, i_addr=0x100; m_ready one cycle after m_req with m_rdata=0x00000013 -> i_ack and i_rdata=0x00000013 at cycle 3; m_we=0, m_be=F.
REQ-036 Contention from reset: i_req and d_req both at cycle 0 (d write 0x1004, 0xCAFEBABE, be=4'b0011) -> D served first with m_we=1; I served next; third contention grants D again.
REQ-037 Back-to-back: d_req held high after ack with new address -> next grant in the IDLE cycle after RESP, fields reflect new address.
REQ-038 Stall: m_ready delayed 10 cycles -> m_req and fields stable for 10 cycles, busy=1, no ack until cycle after m_ready.
REQ-039 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m_ready never asserted -> m_req drops after 4 BUSY cycles, ack=1, rdata=0, timeout_err=1 for one cycle; m_ready in the 4th cycle -> no error.
REQ-040 Reset mid-BUSY: rst_n low for 1 cycle while m_req=1 -> all outputs 0 immediately, no ack; a pending i_req is granted in the first cycle after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-fetch port (i_*), data port (d_*),
// shared-memory port (m_*) and status outputs of mem_arbiter.
//   slave  : the arbiter side (drives acks, rdata, m_* command, status)
//   master : the environment side (requesters and shared memory)
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ready;

  logic        busy;
  logic        timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_be,
           busy, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_be,
           busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) round-robin arbiter in
// front of a single shared memory port. One transaction at a time:
// IDLE (arbitrate) -> BUSY (m_req held until m_ready) -> RESP (one-cycle ack).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (i_*, d_*, m_*, busy, timeout_err)
// Parameter:
//   TIMEOUT_CYCLES : BUSY cycles without m_ready before abort (2..255)
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> BUSY cycles counted; abort with ack, rdata=0, timeout_err=1
//   undefined -> BUSY waits indefinitely, timeout_err tied low
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_d;   // 1: last/current grant is D, 0: I
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_be;
  logic        r_i_ack;
  logic        r_d_ack;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_busy;
  logic        r_to_err;

  logic        w_any_req;
  logic        w_gnt_d;
  logic        w_timeout;

  assign w_any_req = bus.i_req | bus.d_req;
  // D wins when alone, or on contention when I was granted last.
  assign w_gnt_d   = bus.d_req & (~bus.i_req | ~r_last_d);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;

  // r_cnt holds the number of BUSY cycles already completed, so the
  // TIMEOUT_CYCLES-th BUSY cycle sees r_cnt == TIMEOUT_CYCLES-1 and aborts
  // at its end unless m_ready arrives in that same cycle.
  assign w_timeout = (r_state == S_BUSY) && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = ^8'(TIMEOUT_CYCLES);
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_be    <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_busy    <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state  <= S_BUSY;
            r_busy   <= 1'b1;
            r_m_req  <= 1'b1;
            r_last_d <= w_gnt_d;
            if (w_gnt_d) begin
              r_m_we    <= bus.d_we;
              r_m_addr  <= bus.d_addr;
              r_m_wdata <= bus.d_wdata;
              r_m_be    <= bus.d_be;
            end else begin
              r_m_we    <= 1'b0;
              r_m_addr  <= bus.i_addr;
              r_m_wdata <= '0;
              r_m_be    <= 4'hF;
            end
          end
        end
        S_BUSY: begin
          // m_ready takes priority over a coincident timeout.
          if (bus.m_ready || w_timeout) begin
            r_state  <= S_RESP;
            r_m_req  <= 1'b0;
            r_to_err <= ~bus.m_ready;
            if (r_last_d) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= bus.m_ready ? bus.m_rdata : 32'h0;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.m_ready ? bus.m_rdata : 32'h0;
            end
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_i_ack  <= 1'b0;
          r_d_ack  <= 1'b0;
          r_to_err <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m_req       = r_m_req;
  assign bus.m_we        = r_m_we;
  assign bus.m_addr      = r_m_addr;
  assign bus.m_wdata     = r_m_wdata;
  assign bus.m_be        = r_m_be;
  assign bus.i_ack       = r_i_ack;
  assign bus.d_ack       = r_d_ack;
  assign bus.i_rdata     = r_i_rdata;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_to_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven directed transactions, a mid-BUSY reset
// sequence and randomized transactions, all checked against a small
// transaction-level model (round-robin owner, expected latency, rdata).
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  bit          mdl_last_d;
  logic [31:0] mdl_ird;
  logic [31:0] mdl_drd;

  typedef struct {
    bit          ireq;
    bit          dreq;
    bit          dwe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          k;       // cycle of m_ready relative to request cycle 0
    logic [31:0] rd;      // m_rdata driven with m_ready
    bit          exp_d;   // expected owner
    logic [31:0] exp_rd;  // expected rdata on owner's port
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".m_req"},   bus.m_req, 0);
    chk({tag, ".m_we"},    bus.m_we, 0);
    chk({tag, ".m_addr"},  bus.m_addr, 0);
    chk({tag, ".m_wdata"}, bus.m_wdata, 0);
    chk({tag, ".m_be"},    bus.m_be, 0);
    chk({tag, ".i_ack"},   bus.i_ack, 0);
    chk({tag, ".d_ack"},   bus.d_ack, 0);
    chk({tag, ".i_rdata"}, bus.i_rdata, 0);
    chk({tag, ".d_rdata"}, bus.d_rdata, 0);
    chk({tag, ".busy"},    bus.busy, 0);
    chk({tag, ".terr"},    bus.timeout_err, 0);
  endtask

  task automatic set_inputs(input vec_t v);
    bus.i_req   = v.ireq;
    bus.i_addr  = v.iaddr;
    bus.d_req   = v.dreq;
    bus.d_we    = v.dwe;
    bus.d_addr  = v.daddr;
    bus.d_wdata = v.wdata;
    bus.d_be    = v.be;
  endtask

  // Advance into an IDLE cycle; m_ready is poked there to show it is ignored.
  task automatic idle_check();
    @(negedge clk);
    chk("idle.busy",  bus.busy, 0);
    chk("idle.m_req", bus.m_req, 0);
    chk("idle.i_ack", bus.i_ack, 0);
    chk("idle.d_ack", bus.d_ack, 0);
    chk("idle.terr",  bus.timeout_err, 0);
    bus.m_ready = 1'($urandom);
    bus.m_rdata = $urandom;
  endtask

  // Called at the negedge of request cycle 0 with requests applied.
  // Ends at the negedge of the ack (RESP) cycle.
  task automatic run_txn(input int k, input logic [31:0] rd, input bit exp_d,
                         input logic [31:0] exp_rd, input bit exp_err);
    logic        ewe;
    logic [31:0] ea, ew;
    logic [3:0]  ebe;
    int          kk;
    ewe = exp_d ? bus.d_we    : 1'b0;
    ea  = exp_d ? bus.d_addr  : bus.i_addr;
    ew  = exp_d ? bus.d_wdata : 32'h0;
    ebe = exp_d ? bus.d_be    : 4'hF;
    kk  = k;
`ifdef ARB_TIMEOUT_EN
    if (k > TO) kk = TO;
`endif
    for (int c = 1; c <= kk; c++) begin
      @(negedge clk);
      chk("busy.m_req",   bus.m_req, 1);
      chk("busy.m_we",    bus.m_we, ewe);
      chk("busy.m_addr",  bus.m_addr, ea);
      chk("busy.m_wdata", bus.m_wdata, ew);
      chk("busy.m_be",    bus.m_be, ebe);
      chk("busy.busy",    bus.busy, 1);
      chk("busy.i_ack",   bus.i_ack, 0);
      chk("busy.d_ack",   bus.d_ack, 0);
      bus.m_ready = (c == k);
      bus.m_rdata = (c == k) ? rd : $urandom;
    end
    @(negedge clk);
    bus.m_ready = 1'($urandom);
    bus.m_rdata = $urandom;
    if (exp_d) mdl_drd = exp_rd;
    else       mdl_ird = exp_rd;
    mdl_last_d = exp_d;
    chk("resp.i_ack",   bus.i_ack, !exp_d);
    chk("resp.d_ack",   bus.d_ack, exp_d);
    chk("resp.i_rdata", bus.i_rdata, mdl_ird);
    chk("resp.d_rdata", bus.d_rdata, mdl_drd);
    chk("resp.m_req",   bus.m_req, 0);
    chk("resp.busy",    bus.busy, 1);
    chk("resp.terr",    bus.timeout_err, exp_err);
  endtask

  initial begin
    vec_t v;
    bit   ed, terr;
    logic [31:0] erd;
    total = 0;
    bad   = 0;
    mdl_last_d = 1'b0;
    mdl_ird = '0;
    mdl_drd = '0;

    //            ireq dreq dwe iaddr      daddr      wdata         be     k   rd            exp_d exp_rd        err
    vecs[0] = '{1, 0, 0, 32'h100, 32'h0,    32'h0,        4'hF,  2,  32'h00000013, 0, 32'h00000013, 0};
    vecs[1] = '{1, 1, 1, 32'h200, 32'h1004, 32'hCAFEBABE, 4'b0011, 1, 32'hDEAD0001, 1, 32'hDEAD0001, 0};
    vecs[2] = '{1, 0, 0, 32'h200, 32'h1004, 32'h0,        4'hF,  1,  32'h11112222, 0, 32'h11112222, 0};
    vecs[3] = '{1, 1, 0, 32'h300, 32'h2000, 32'h0,        4'hF,  3,  32'h33334444, 1, 32'h33334444, 0};
    vecs[4] = '{0, 1, 0, 32'h300, 32'h2004, 32'h0,        4'hC,  1,  32'h00000055, 1, 32'h00000055, 0};
    vecs[5] = '{1, 1, 1, 32'h304, 32'h2008, 32'h12345678, 4'h1,  4,  32'h00000066, 0, 32'h00000066, 0};
`ifdef ARB_TIMEOUT_EN
    vecs[6] = '{0, 1, 0, 32'h0,   32'h3000, 32'h0,        4'hF, 10,  32'h5555AAAA, 1, 32'h00000000, 1};
`else
    vecs[6] = '{0, 1, 0, 32'h0,   32'h3000, 32'h0,        4'hF, 10,  32'h5555AAAA, 1, 32'h5555AAAA, 0};
`endif
    vecs[7] = '{1, 0, 0, 32'h400, 32'h0,    32'h0,        4'hF,  1,  32'h00000077, 0, 32'h00000077, 0};

    rst_n       = 1'b0;
    bus.i_req   = 0; bus.i_addr  = '0;
    bus.d_req   = 0; bus.d_we    = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.m_ready = 0; bus.m_rdata = '0;
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    foreach (vecs[i]) begin
      idle_check();
      set_inputs(vecs[i]);
      run_txn(vecs[i].k, vecs[i].rd, vecs[i].exp_d, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // reset while BUSY: outputs clear at once, no ack, pending i_req granted
    idle_check();
    v = '{1, 0, 0, 32'h500, 32'h0, 32'h0, 4'hF, 1, 32'h0, 0, 32'h0, 0};
    set_inputs(v);
    @(negedge clk);
    chk("mid.m_req", bus.m_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(posedge clk);
    #1;
    chk("midrst.i_ack", bus.i_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last_d = 1'b0;
    mdl_ird = '0;
    mdl_drd = '0;
    run_txn(2, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);
    // after reset last_grant is I again: a contention goes to D
    idle_check();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mdl_last_d = 1'b0;
    mdl_ird = '0;
    mdl_drd = '0;
    v = '{1, 1, 0, 32'h600, 32'h6000, 32'h0, 4'hF, 1, 32'hBEEF0000, 1, 32'hBEEF0000, 0};
    set_inputs(v);
    run_txn(v.k, v.rd, v.exp_d, v.exp_rd, v.exp_err);

    // randomized transactions against the model
    for (int n = 0; n < 60; n++) begin
      int sel;
      idle_check();
      sel     = $urandom_range(1, 3);
      v.ireq  = (sel != 2);
      v.dreq  = (sel != 1);
      v.dwe   = 1'($urandom);
      v.iaddr = $urandom;
      v.daddr = $urandom;
      v.wdata = $urandom;
      v.be    = 4'($urandom);
      v.k     = $urandom_range(1, 8);
      v.rd    = $urandom;
      set_inputs(v);
      ed   = v.dreq && (!v.ireq || !mdl_last_d);
      erd  = v.rd;
      terr = 1'b0;
`ifdef ARB_TIMEOUT_EN
      if (v.k > TO) begin
        erd  = 32'h0;
        terr = 1'b1;
      end
`endif
      run_txn(v.k, v.rd, ed, erd, terr);
    end

    idle_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
